i2s_tx_multi: RTL

Parametrised stereo I2S transmitter: accepts left/right sample pairs from the filter over a ready-to-send/ready-to-receive handshake, buffers them in an internal FIFO of configurable depth, and serialises them MSB-first onto i2so_sd/i2so_ws. It supports configurable sample and slot widths, I2S (one-bit delay) or left-justified format, an enable gate, a FIFO fill-level readout, and a sticky underrun flag. It sits between the filter output and the DAC pins, and replaces the fixed 32-bit i2s_out.

---
 rtl/i2s_tx_multi.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/i2s_tx_multi.sv
// i2s_tx_multi: FIFO-buffered stereo serialiser driving I2S (one-bit delay) or left-justified DAC pins.
// Define I2SO_REPEAT_ON_UNDERRUN_EN to resend the last popped pair on underrun instead of an all-zero pair.
module i2s_tx_multi #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int FIFO_AW    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sck_inp,
    input  logic                    sck_fall,
    input  logic                    en,
    input  logic                    fmt_lj,
    input  logic                    filt_rts,
    input  logic [2*DATA_WIDTH-1:0] filt_data,
    output logic                    filt_rtr,
    input  logic                    trig_fifo_underrun,
    output logic                    i2so_sck,
    output logic                    i2so_ws,
    output logic                    i2so_sd,
    output logic                    ro_fifo_underrun,
    output logic [FIFO_AW:0]        ro_fifo_level
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int FRAME = 2 * SLOT_WIDTH;
    localparam int CW    = $clog2(FRAME);

    logic [PW-1:0]    r_mem [DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_running;
    logic             r_fmt_lj;
    logic             r_prev_lj;
    logic [FRAME-1:0] r_shift;
    logic             r_ws;
    logic             r_sd;
    logic             r_underrun;

    logic [FIFO_AW:0] w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_frame_start;
    logic             w_underrun_evt;
    logic [CW-1:0]    w_next_cnt;
    logic [PW-1:0]    w_fifo_head;
    logic [PW-1:0]    w_underrun_pair;
    logic [PW-1:0]    w_load_pair;
    logic [FRAME-1:0] w_frame;
    logic             w_lj_bit;
    logic             w_fmt_lj;

    // Handshake: a pair transfers on every clk edge where filt_rts && filt_rtr are both high;
    // filt_rtr depends only on the registered pointers (!full), never on filt_rts.
    assign w_level  = r_wr_ptr - r_rd_ptr;
    assign w_full   = w_level[FIFO_AW];
    assign w_empty  = (w_level == '0);
    assign w_push   = filt_rts & ~w_full;
    assign filt_rtr = ~w_full;

    // A frame starts on the first SCK fall after enable, and on every wrap thereafter.
    assign w_frame_start  = sck_fall & en & (~r_running | (r_bit_cnt == CW'(FRAME - 1)));
    assign w_next_cnt     = w_frame_start ? '0 : r_bit_cnt + CW'(1);
    assign w_pop          = w_frame_start & ~w_empty;
    assign w_underrun_evt = w_frame_start & w_empty;
    assign w_fifo_head    = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign w_load_pair    = w_empty ? w_underrun_pair : w_fifo_head;

`ifdef I2SO_REPEAT_ON_UNDERRUN_EN
    logic [PW-1:0] r_last_pair;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_pair <= '0;
        end else if (w_pop) begin
            r_last_pair <= w_fifo_head;
        end
    end

    assign w_underrun_pair = r_last_pair;
`else
    assign w_underrun_pair = '0;
`endif

    // Left-justified frame image: each channel's MSB sits at the top of its slot, padding below.
    always_comb begin
        w_frame = '0;
        w_frame[FRAME-1 -: DATA_WIDTH]      = w_load_pair[PW-1 -: DATA_WIDTH];
        w_frame[SLOT_WIDTH-1 -: DATA_WIDTH] = w_load_pair[DATA_WIDTH-1:0];
    end

    assign w_lj_bit = w_frame_start ? w_frame[FRAME-1] : r_shift[FRAME-1];
    assign w_fmt_lj = w_frame_start ? fmt_lj : r_fmt_lj;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= filt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_running <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_fmt_lj  <= 1'b0;
            r_prev_lj <= 1'b0;
            r_ws      <= 1'b0;
            r_sd      <= 1'b0;
        end else if (sck_fall) begin
            if (!en) begin
                r_running <= 1'b0;
                r_bit_cnt <= '0;
                r_prev_lj <= 1'b0;
                r_ws      <= 1'b0;
                r_sd      <= 1'b0;
            end else begin
                r_running <= 1'b1;
                r_bit_cnt <= w_next_cnt;
                r_shift   <= w_frame_start ? (w_frame << 1) : (r_shift << 1);
                // I2S output lags the left-justified stream by one SCK period.
                r_prev_lj <= w_lj_bit;
                r_sd      <= w_fmt_lj ? w_lj_bit : r_prev_lj;
                r_ws      <= (w_next_cnt >= CW'(SLOT_WIDTH));
                if (w_frame_start) r_fmt_lj <= fmt_lj;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_evt) begin
            r_underrun <= 1'b1;
        end else if (trig_fifo_underrun) begin
            r_underrun <= 1'b0;
        end
    end

    assign i2so_sck         = sck_inp;
    assign i2so_ws          = r_ws;
    assign i2so_sd          = r_sd;
    assign ro_fifo_underrun = r_underrun;
    assign ro_fifo_level    = w_level;

endmodule
